// File: rtl/fir_pkg.sv
// Shared types and constants for the 4-lane FIR MAC engine.
// Lane widths, accumulator width, FSM encoding and output clip limits.
package fir_pkg;

    localparam int DATA_W  = 18;
    localparam int ACC_W   = 48;
    localparam int LANES   = 4;
    localparam int ADDR_W  = 12;
    localparam int WORD_W  = LANES * DATA_W;
    localparam int PROD_W  = 2 * DATA_W;
    localparam int SUM_W   = PROD_W + 2;
    localparam int SAT_MAX = 131071;
    localparam int SAT_MIN = -131072;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        OUT
    } state_e;

endpackage

// File: rtl/fir_mac4_engine_mac4_lane.sv
// Four signed lane multipliers followed by a registered adder tree.
// Two register stages: products, then their 38-bit sum.
module mac4_lane
    import fir_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WORD_W-1:0]       a_i,
    input  logic [WORD_W-1:0]       b_i,
    input  logic                    vld_i,
    output logic signed [SUM_W-1:0] sum_o,
    output logic                    vld_o
);

    logic signed [PROD_W-1:0] prod_d [LANES];
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic                     prod_vld_q;
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [SUM_W-1:0]  sum_q;
    logic                     sum_vld_q;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = PROD_W'($signed(a_i[i*DATA_W +: DATA_W]))
                      * PROD_W'($signed(b_i[i*DATA_W +: DATA_W]));
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + SUM_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
            prod_vld_q <= 1'b0;
            sum_q      <= '0;
            sum_vld_q  <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
            prod_vld_q <= vld_i;
            sum_q      <= sum_d;
            sum_vld_q  <= prod_vld_q;
        end
    end

    assign sum_o = sum_q;
    assign vld_o = sum_vld_q;

endmodule

// File: rtl/fir_mac4_engine.sv
// FIR engine: sweeps buffer/coef addresses, accumulates 4-lane MACs,
// then emits one rounded, saturated sample per start request.
module fir_mac4_engine
    import fir_pkg::*;
#(
    parameter int OUT_SHIFT = 17
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        len_m1,
    output logic [ADDR_W-1:0]        buf_addr,
    input  logic [WORD_W-1:0]        buf_data,
    output logic [ADDR_W-1:0]        coef_addr,
    input  logic [WORD_W-1:0]        coef_data,
    output logic                     busy,
    output logic signed [DATA_W-1:0] dout,
    output logic                     dout_valid,
    output logic                     sat
);

    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< (OUT_SHIFT - 1);
    localparam logic signed [ACC_W-1:0] HI  = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] LO  = ACC_W'(SAT_MIN);

    state_e                    state_q;
    logic [ADDR_W-1:0]         len_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [1:0]                flush_q;
    logic                      busy_q;
    logic signed [DATA_W-1:0]  dout_q;
    logic signed [DATA_W-1:0]  dout_d;
    logic                      dv_q;
    logic                      sat_q;
    logic                      sat_d;
    logic                      rd_vld_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   rnd_w;
    logic signed [SUM_W-1:0]   sum_w;
    logic                      sum_vld_w;

    mac4_lane u_mac (
        .clock (clock),
        .reset (reset),
        .a_i   (buf_data),
        .b_i   (coef_data),
        .vld_i (rd_vld_q),
        .sum_o (sum_w),
        .vld_o (sum_vld_w)
    );

    // Round half up, then clip to the 18-bit signed output range.
    always_comb begin
        rnd_w  = (acc_q + RND) >>> OUT_SHIFT;
        sat_d  = 1'b0;
        dout_d = rnd_w[DATA_W-1:0];
        if (rnd_w > HI) begin
            sat_d  = 1'b1;
            dout_d = DATA_W'(SAT_MAX);
        end else if (rnd_w < LO) begin
            sat_d  = 1'b1;
            dout_d = DATA_W'(SAT_MIN);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_vld_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            rd_vld_q <= (state_q == RUN);
            if (state_q == IDLE && start) begin
                acc_q <= '0;
            end else if (sum_vld_w) begin
                acc_q <= acc_q + ACC_W'(sum_w);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            flush_q <= '0;
            busy_q  <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    busy_q <= start;
                    if (start) begin
                        len_q   <= len_m1;
                        addr_q  <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (addr_q == len_q) begin
                        addr_q  <= '0;
                        flush_q <= '0;
                        state_q <= FLUSH;
                    end else begin
                        addr_q <= addr_q + 1'b1;
                    end
                end
                FLUSH: begin
                    flush_q <= flush_q + 2'd1;
                    if (flush_q == 2'd2) begin
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    dout_q  <= dout_d;
                    sat_q   <= sat_d;
                    dv_q    <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign buf_addr   = addr_q;
    assign coef_addr  = addr_q;
    assign busy       = busy_q;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign sat        = sat_q;

endmodule
